// File: rtl/cache_pkg.sv
// Shared state encoding and address-field sizing for the blocking cache controller.
package cache_pkg;

  localparam int ADDR_W           = 32;
  localparam int WORD_W           = 32;
  localparam int OFFSET_WIDTH_DEF = 3;
  localparam int INDEX_WIDTH_DEF  = 6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_VICTIM = 3'd2,
    S_WB     = 3'd3,
    S_REFILL = 3'd4,
    S_FILL   = 3'd5
  } state_t;

  function automatic int tag_width(input int offset_w, input int index_w);
    return ADDR_W - 2 - offset_w - index_w;
  endfunction

  function automatic int block_width(input int offset_w);
    return WORD_W << offset_w;
  endfunction

endpackage

// File: rtl/cache_ctrl.sv
// Blocking write-back/write-allocate controller sitting between a CPU port,
// a 2-way tag/data array and a block-wide memory port.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int OFFSET_WIDTH = OFFSET_WIDTH_DEF,
  parameter int INDEX_WIDTH  = INDEX_WIDTH_DEF,
  localparam int T = tag_width(OFFSET_WIDTH, INDEX_WIDTH),
  localparam int B = block_width(OFFSET_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [31:0]             cpu_addr,
  input  logic [3:0]              cpu_byte_en,
  input  logic [31:0]             cpu_wdata,
  output logic [31:0]             cpu_rdata,
  output logic                    cpu_ready,
  output logic                    cache_enable,
  output logic                    cache_cmp,
  output logic                    cache_write,
  output logic                    cache_valid_in,
  output logic [3:0]              cache_byte_w_en,
  output logic [T-1:0]            cache_tag,
  output logic [INDEX_WIDTH-1:0]  cache_index,
  output logic [OFFSET_WIDTH-1:0] cache_word_sel,
  output logic [31:0]             cache_data_in,
  output logic [B-1:0]            cache_data_block_in,
  input  logic                    cache_hit,
  input  logic                    cache_dirty,
  input  logic [T-1:0]            cache_tag_out,
  input  logic [31:0]             cache_data_out,
  input  logic [B-1:0]            cache_data_wb,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [B-1:0]            mem_wdata,
  input  logic [B-1:0]            mem_rdata,
  input  logic                    mem_ack,
  output logic [31:0]             miss_cnt
);

  localparam int IDX_LO = OFFSET_WIDTH + 2;
  localparam int IDX_HI = INDEX_WIDTH + OFFSET_WIDTH + 1;
  localparam int TAG_LO = 32 - T;

  state_t         state_q, state_d;
  logic           req_we_q, req_we_d;
  logic [31:2]    req_addr_q, req_addr_d;
  logic [3:0]     req_be_q, req_be_d;
  logic [31:0]    req_wdata_q, req_wdata_d;
  logic [T-1:0]   victim_tag_q, victim_tag_d;
  logic [B-1:0]   victim_blk_q, victim_blk_d;
  logic [B-1:0]   fill_blk_q, fill_blk_d;
  logic [31:0]    miss_cnt_q, miss_cnt_d;

  logic [T-1:0]           req_tag;
  logic [INDEX_WIDTH-1:0] req_index;
  logic                   unused_addr_lsb;

  assign req_tag         = req_addr_q[31:TAG_LO];
  assign req_index       = req_addr_q[IDX_HI:IDX_LO];
  assign unused_addr_lsb = ^cpu_addr[1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_be_q     <= '0;
      req_wdata_q  <= '0;
      victim_tag_q <= '0;
      victim_blk_q <= '0;
      fill_blk_q   <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      req_we_q     <= req_we_d;
      req_addr_q   <= req_addr_d;
      req_be_q     <= req_be_d;
      req_wdata_q  <= req_wdata_d;
      victim_tag_q <= victim_tag_d;
      victim_blk_q <= victim_blk_d;
      fill_blk_q   <= fill_blk_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    req_we_d        = req_we_q;
    req_addr_d      = req_addr_q;
    req_be_d        = req_be_q;
    req_wdata_d     = req_wdata_q;
    victim_tag_d    = victim_tag_q;
    victim_blk_d    = victim_blk_q;
    fill_blk_d      = fill_blk_q;
    miss_cnt_d      = miss_cnt_q;
    cpu_ready       = 1'b0;
    cpu_rdata       = '0;
    cache_enable    = 1'b0;
    cache_cmp       = 1'b0;
    cache_write     = 1'b0;
    cache_valid_in  = 1'b0;
    cache_byte_w_en = '0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;

    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          req_we_d    = cpu_we;
          req_addr_d  = cpu_addr[31:2];
          req_be_d    = cpu_byte_en;
          req_wdata_d = cpu_wdata;
          state_d     = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        cache_enable    = 1'b1;
        cache_cmp       = 1'b1;
        cache_write     = req_we_q;
        cache_byte_w_en = req_be_q;
        if (cache_hit) begin
          cpu_ready = 1'b1;
          cpu_rdata = cache_data_out;
          state_d   = S_IDLE;
        end else begin
          miss_cnt_d = miss_cnt_q + 32'd1;
          state_d    = S_VICTIM;
        end
      end
      S_VICTIM: begin
        cache_enable = 1'b1;
        victim_tag_d = cache_tag_out;
        victim_blk_d = cache_data_wb;
        state_d      = cache_dirty ? S_WB : S_REFILL;
      end
      S_WB: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {victim_tag_q, req_index, {(OFFSET_WIDTH + 2){1'b0}}};
        if (mem_ack) state_d = S_REFILL;
      end
      S_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_index, {(OFFSET_WIDTH + 2){1'b0}}};
        if (mem_ack) begin
          fill_blk_d = mem_rdata;
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        // Whole-block fill; a pending store is merged on the LOOKUP retry.
        cache_enable    = 1'b1;
        cache_write     = 1'b1;
        cache_valid_in  = 1'b1;
        cache_byte_w_en = 4'hF;
        state_d         = S_LOOKUP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cache_tag           = req_tag;
  assign cache_index         = req_index;
  assign cache_word_sel      = req_addr_q[OFFSET_WIDTH+1:2];
  assign cache_data_in       = req_wdata_q;
  assign cache_data_block_in = fill_blk_q;
  assign mem_wdata           = victim_blk_q;
  assign miss_cnt            = miss_cnt_q;

endmodule
